median9_pipe: RTL
=================

Name: median9_pipe

Overview:
- Streaming median-of-9 filter core built from compare-exchange (min/max) cells.
- Successor to the single combinational 8-bit compare-exchange cell: parametrised data width, selectable signed/unsigned compare, 3-stage registered pipeline with valid/ready handshake.
- Sits between the 3x3 window generator and the output pixel stream of the median filter.

Parameters:
- DATA_W, 8, bit width of each sample.
- SIGNED, 0, compare mode: 0 = unsigned, 1 = two's complement.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  WIN holds a valid window.
- IN_READY  out  1  core accepts WIN this cycle.
- WIN  in  9*DATA_W  window; sample k at [k*DATA_W +: DATA_W]; row r = samples 3r, 3r+1, 3r+2.
- OUT_VALID  out  1  MED holds a valid result.
- OUT_READY  in  1  downstream accepts MED.
- MED  out  DATA_W  median of the 9 samples.

Behaviour:
- Compare-exchange cell: lo = smaller, hi = larger of two operands under SIGNED mode. Equal operands give lo = hi = operand value, so tie order is irrelevant.
- Stage 1: each row is sorted into (min_r, med_r, max_r) by 3 compare-exchanges. 9 values plus valid v1 are registered.
- Stage 2: registers the following, plus v2:
  - lo = max(min_0, min_1, min_2)
  - mid = median(med_0, med_1, med_2)
  - hi = min(max_0, max_1, max_2)
- Stage 3: MED = median(lo, mid, hi), registered with v3. OUT_VALID = v3.
- Latency: 3 cycles from the accepting edge (IN_VALID & IN_READY) to OUT_VALID. Throughput is 1 window per cycle when OUT_READY = 1.
- Advance: adv = !v3 | OUT_READY, and IN_READY = adv (combinational from OUT_READY).
  - When adv = 1, all stages shift: v1 <= IN_VALID, v2 <= v1, v3 <= v2. Data registers load regardless of their valid bit.
  - When adv = 0, all stages hold (global enable). No bubble compression.
- Output hold: while OUT_VALID = 1 and OUT_READY = 0, MED and OUT_VALID stay stable.
- Upstream: WIN is sampled only on IN_VALID & IN_READY. If IN_VALID is low, a bubble (valid = 0) enters.
- Reset: v1, v2, v3, OUT_VALID = 0; all data registers and MED = 0; IN_READY = 1 during and after reset.
  - Reset mid-stream discards all in-flight windows; no partial result ever appears.
  - Reset has priority over adv.
- Widths: no arithmetic, only compares and selects, so results never exceed DATA_W. SIGNED = 1 compares MSB-inverted operands as unsigned (equivalent to signed compare).
- Extremes: all-equal window gives MED = that value. Values 0 and 2^DATA_W-1 need no special handling.

Optional Feature:
- Macro MEDIAN9_MINMAX_EN.
- Defined:
  - Extra output ports WMIN and WMAX, both out, DATA_W wide.
  - WMIN = min(min_0, min_1, min_2) and WMAX = max(max_0, max_1, max_2), computed in stage 2.
  - Both are carried through stage 3, aligned with MED. They share OUT_VALID, stall and reset (reset value 0).
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- DATA_W = 8, SIGNED = 0: WIN = {9,1,8,2,7,3,6,4,5} (sample 0 first), IN_VALID for 1 cycle, OUT_READY = 1 -> OUT_VALID high exactly 3 cycles later for 1 cycle, MED = 5. With MEDIAN9_MINMAX_EN: WMIN = 1, WMAX = 9.
- WIN = {0x80,0x7F,0xFF,0x01,0x00,0xFE,0x02,0x03,0xFD}:
  - SIGNED = 1 -> MED = 0x00 (WMIN = 0x80, WMAX = 0x7F).
  - SIGNED = 0 -> MED = 0x7F (WMIN = 0x00, WMAX = 0xFF).
- Back-to-back stream of 20 random windows, IN_VALID and OUT_READY held high -> 20 consecutive OUT_VALID cycles, each MED matching a software sort reference, in order.
- Backpressure: during a 6-window stream, drop OUT_READY for 4 cycles while OUT_VALID = 1 -> IN_READY = 0 those cycles, MED/OUT_VALID stable, no window lost or duplicated, order preserved.
- All 9 samples = 0xFF, then all = 0x00; DATA_W = 12 run with all = 0xABC -> MED equals the repeated value in each case.
- Assert RESET for 1 cycle while 3 windows are in flight -> next cycle OUT_VALID = 0, MED = 0, IN_READY = 1; no flushed window ever appears at the output; the next window accepted yields a correct result 3 cycles later.

Source files
------------

// File: rtl/median9_pipe_if.sv
// Stream interface for the median-of-9 core: window in, median out.
// MEDIAN9_MINMAX_EN adds the window min/max result lanes.
interface median9_pipe_if #(
    parameter int DATA_W = 8
);
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [9*DATA_W-1:0]   WIN;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DATA_W-1:0]     MED;
`ifdef MEDIAN9_MINMAX_EN
    logic [DATA_W-1:0]     WMIN;
    logic [DATA_W-1:0]     WMAX;

    modport master (
        output IN_VALID, WIN, OUT_READY,
        input  IN_READY, OUT_VALID, MED, WMIN, WMAX
    );
    modport slave (
        input  IN_VALID, WIN, OUT_READY,
        output IN_READY, OUT_VALID, MED, WMIN, WMAX
    );
`else
    modport master (
        output IN_VALID, WIN, OUT_READY,
        input  IN_READY, OUT_VALID, MED
    );
    modport slave (
        input  IN_VALID, WIN, OUT_READY,
        output IN_READY, OUT_VALID, MED
    );
`endif
endinterface

// File: rtl/median9_pipe.sv
// Streaming median-of-9 filter: row sort, column reduce, final median3; 3 register stages.
// Optional macro MEDIAN9_MINMAX_EN adds window min/max outputs aligned with MED.
module median9_pipe #(
    parameter int DATA_W = 8,
    parameter bit SIGNED = 1'b0
) (
    input logic          CLK,
    input logic          RESET,
    median9_pipe_if.slave s
);
    // Signed order equals unsigned order once the sign bit is inverted.
    localparam logic [DATA_W-1:0] FLIP = SIGNED ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a ^ FLIP) < (b ^ FLIP);
    endfunction

    function automatic logic [DATA_W-1:0] vmin(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return lt(b, a) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return lt(b, a) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return vmax(vmin(a, b), vmin(vmax(a, b), c));
    endfunction

    logic [DATA_W-1:0] samp    [9];
    logic [DATA_W-1:0] row_min [3];
    logic [DATA_W-1:0] row_med [3];
    logic [DATA_W-1:0] row_max [3];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_samp
            assign samp[gi] = s.WIN[gi*DATA_W +: DATA_W];
        end
        // Three compare-exchanges per row: (a,b), (max,c), then the two lows.
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_W-1:0] l0, h0, l1, h1;
            assign l0 = vmin(samp[3*gi], samp[3*gi+1]);
            assign h0 = vmax(samp[3*gi], samp[3*gi+1]);
            assign l1 = vmin(h0, samp[3*gi+2]);
            assign h1 = vmax(h0, samp[3*gi+2]);
            assign row_min[gi] = vmin(l0, l1);
            assign row_med[gi] = vmax(l0, l1);
            assign row_max[gi] = h1;
        end
    endgenerate

    logic              adv;
    logic              v1_reg, v2_reg, v3_reg;
    logic [DATA_W-1:0] s1_min_reg [3];
    logic [DATA_W-1:0] s1_med_reg [3];
    logic [DATA_W-1:0] s1_max_reg [3];
    logic [DATA_W-1:0] lo_reg, mid_reg, hi_reg;
    logic [DATA_W-1:0] lo_next, mid_next, hi_next;
    logic [DATA_W-1:0] med_reg, med_next;

    // Global enable: the whole pipe stalls only when a held result is refused.
    assign adv        = !v3_reg || s.OUT_READY;
    assign s.IN_READY = adv;
    assign s.OUT_VALID = v3_reg;
    assign s.MED      = med_reg;

    assign lo_next  = vmax(vmax(s1_min_reg[0], s1_min_reg[1]), s1_min_reg[2]);
    assign mid_next = med3(s1_med_reg[0], s1_med_reg[1], s1_med_reg[2]);
    assign hi_next  = vmin(vmin(s1_max_reg[0], s1_max_reg[1]), s1_max_reg[2]);
    assign med_next = med3(lo_reg, mid_reg, hi_reg);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            v3_reg  <= 1'b0;
            lo_reg  <= '0;
            mid_reg <= '0;
            hi_reg  <= '0;
            med_reg <= '0;
            for (int i = 0; i < 3; i++) begin
                s1_min_reg[i] <= '0;
                s1_med_reg[i] <= '0;
                s1_max_reg[i] <= '0;
            end
        end else if (adv) begin
            v1_reg  <= s.IN_VALID;
            v2_reg  <= v1_reg;
            v3_reg  <= v2_reg;
            lo_reg  <= lo_next;
            mid_reg <= mid_next;
            hi_reg  <= hi_next;
            med_reg <= med_next;
            for (int i = 0; i < 3; i++) begin
                s1_min_reg[i] <= row_min[i];
                s1_med_reg[i] <= row_med[i];
                s1_max_reg[i] <= row_max[i];
            end
        end
    end

`ifdef MEDIAN9_MINMAX_EN
    logic [DATA_W-1:0] wmin_s2_reg, wmax_s2_reg;
    logic [DATA_W-1:0] wmin_reg, wmax_reg;
    logic [DATA_W-1:0] wmin_next, wmax_next;

    assign wmin_next = vmin(vmin(s1_min_reg[0], s1_min_reg[1]), s1_min_reg[2]);
    assign wmax_next = vmax(vmax(s1_max_reg[0], s1_max_reg[1]), s1_max_reg[2]);
    assign s.WMIN    = wmin_reg;
    assign s.WMAX    = wmax_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wmin_s2_reg <= '0;
            wmax_s2_reg <= '0;
            wmin_reg    <= '0;
            wmax_reg    <= '0;
        end else if (adv) begin
            wmin_s2_reg <= wmin_next;
            wmax_s2_reg <= wmax_next;
            wmin_reg    <= wmin_s2_reg;
            wmax_reg    <= wmax_s2_reg;
        end
    end
`endif
endmodule
